regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/core_pkg.sv | 12 +
 rtl/regfile_wb.sv | 117 +++++++++++
 tb/tb_regfile_wb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: default register-file geometry and the writeback entry format.
package core_pkg;

  localparam int RADDRWIDTH = 3;
  localparam int REGWIDTH   = 16;

  typedef struct packed {
    logic [RADDRWIDTH-1:0] waddr;
    logic [REGWIDTH-1:0]   wdata;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb.sv
// Writeback queue merging load and ALU results into the single register-file write port,
// with bypass lookup and a per-register pending-write mask.
module regfile_wb #(
  parameter int RADDRWIDTH = core_pkg::RADDRWIDTH,
  parameter int REGWIDTH   = core_pkg::REGWIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [RADDRWIDTH-1:0]        mem_waddr,
  input  logic [REGWIDTH-1:0]          mem_wdata,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [RADDRWIDTH-1:0]        alu_waddr,
  input  logic [REGWIDTH-1:0]          alu_wdata,
  output logic                         we,
  output logic [RADDRWIDTH-1:0]        waddr,
  output logic [REGWIDTH-1:0]          wdata,
  input  logic [RADDRWIDTH-1:0]        fwd_addr_a,
  input  logic [RADDRWIDTH-1:0]        fwd_addr_b,
  output logic                         fwd_hit_a,
  output logic [REGWIDTH-1:0]          fwd_data_a,
  output logic                         fwd_hit_b,
  output logic [REGWIDTH-1:0]          fwd_data_b,
  output logic [2**RADDRWIDTH-1:0]     pending,
  output logic [$clog2(DEPTH):0]       count
);
  import core_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    alu_slot;
  logic [PW-1:0]    scan_idx;
  logic [CW-1:0]    count_q;
  logic             mem_en;
  logic             alu_en;
  logic             deq;

  // The alu port yields the last free slot to mem so that at most DEPTH entries ever exist.
  assign mem_ready = rst_n && (count_q < CW'(DEPTH));
  assign alu_ready = rst_n && ((count_q <= CW'(DEPTH - 2)) ||
                               ((count_q == CW'(DEPTH - 1)) && !mem_valid));

  assign mem_en   = mem_valid && mem_ready && (mem_waddr != '0);
  assign alu_en   = alu_valid && alu_ready && (alu_waddr != '0);
  assign deq      = (count_q != '0);
  assign alu_slot = wr_ptr + PW'(mem_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      ent_valid <= '0;
    end else begin
      if (deq) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (mem_en) ent_valid[wr_ptr] <= 1'b1;
      if (alu_en) ent_valid[alu_slot] <= 1'b1;
      wr_ptr  <= wr_ptr + PW'(mem_en) + PW'(alu_en);
      count_q <= count_q + CW'(mem_en) + CW'(alu_en) - CW'(deq);
    end
  end

  // Entry payloads need no reset; their valid bits alone decide visibility.
  always_ff @(posedge clk) begin
    if (mem_en) entries[wr_ptr]   <= '{waddr: mem_waddr, wdata: mem_wdata};
    if (alu_en) entries[alu_slot] <= '{waddr: alu_waddr, wdata: alu_wdata};
  end

  // Scanning oldest to youngest lets the youngest matching entry win the bypass.
  always_comb begin
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    pending    = '0;
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    scan_idx   = '0;
    if (rst_n) begin
      if (count_q != '0) begin
        we    = 1'b1;
        waddr = entries[rd_ptr].waddr;
        wdata = entries[rd_ptr].wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        scan_idx = rd_ptr + PW'(k);
        if (ent_valid[scan_idx]) begin
          pending[entries[scan_idx].waddr] = 1'b1;
          if ((fwd_addr_a != '0) && (entries[scan_idx].waddr == fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = entries[scan_idx].wdata;
          end
          if ((fwd_addr_b != '0) && (entries[scan_idx].waddr == fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = entries[scan_idx].wdata;
          end
        end
      end
      pending[0] = 1'b0;
    end
  end

  assign count = rst_n ? count_q : '0;

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized self-checking bench for regfile_wb against a queue-based reference model.
module tb_regfile_wb;
  import core_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_ready, alu_valid, alu_ready;
  logic [2:0]  mem_waddr, alu_waddr, waddr, fwd_addr_a, fwd_addr_b;
  logic [15:0] mem_wdata, alu_wdata, wdata, fwd_data_a, fwd_data_b;
  logic        we, fwd_hit_a, fwd_hit_b;
  logic [7:0]  pending;
  logic [2:0]  count;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } ref_entry_t;

  ref_entry_t model_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  regfile_wb #(.RADDRWIDTH(3), .REGWIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic applyStimulus(input logic rn,
                               input logic mv, input logic [2:0] ma, input logic [15:0] md,
                               input logic av, input logic [2:0] aa, input logic [15:0] ad,
                               input logic [2:0] fa, input logic [2:0] fb);
    int         sz;
    logic       e_mr, e_ar, e_we, e_ha, e_hb;
    logic [2:0] e_wa;
    logic [15:0] e_wd, e_da, e_db;
    logic [7:0] e_pend;
    @(negedge clk);
    rst_n = rn; mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    fwd_addr_a = fa; fwd_addr_b = fb;
    #1;
    sz   = rn ? model_q.size() : 0;
    e_mr = rn && (sz < DEPTH);
    e_ar = rn && ((sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !mv));
    e_we = (sz > 0);
    e_wa = e_we ? model_q[0].a : 3'd0;
    e_wd = e_we ? model_q[0].d : 16'd0;
    e_pend = 8'd0; e_ha = 1'b0; e_hb = 1'b0; e_da = 16'd0; e_db = 16'd0;
    for (int i = 0; i < sz; i++) begin
      e_pend[model_q[i].a] = 1'b1;
      if (fa != 0 && model_q[i].a == fa) begin e_ha = 1'b1; e_da = model_q[i].d; end
      if (fb != 0 && model_q[i].a == fb) begin e_hb = 1'b1; e_db = model_q[i].d; end
    end
    checkOutput("mem_ready", 32'(mem_ready), 32'(e_mr));
    checkOutput("alu_ready", 32'(alu_ready), 32'(e_ar));
    checkOutput("count", 32'(count), 32'(sz));
    checkOutput("we", 32'(we), 32'(e_we));
    checkOutput("waddr", 32'(waddr), 32'(e_wa));
    checkOutput("wdata", 32'(wdata), 32'(e_wd));
    checkOutput("pending", 32'(pending), 32'(e_pend));
    checkOutput("fwd_hit_a", 32'(fwd_hit_a), 32'(e_ha));
    checkOutput("fwd_data_a", 32'(fwd_data_a), 32'(e_da));
    checkOutput("fwd_hit_b", 32'(fwd_hit_b), 32'(e_hb));
    checkOutput("fwd_data_b", 32'(fwd_data_b), 32'(e_db));
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (mv && e_mr && ma != 0) model_q.push_back('{a: ma, d: md});
      if (av && e_ar && aa != 0) model_q.push_back('{a: aa, d: ad});
    end
  endtask

  task automatic idleCycles(input int n, input logic [2:0] fa, input logic [2:0] fb);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, fa, fb);
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_waddr = '0; mem_wdata = '0; alu_waddr = '0; alu_wdata = '0;
    fwd_addr_a = '0; fwd_addr_b = '0;

    // Reset with traffic offered: everything must be dropped.
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h1111, 1'b1, 3'd4, 16'h2222, 3'd3, 3'd4);
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h1111, 1'b1, 3'd4, 16'h2222, 3'd3, 3'd4);

    // Single write, then drain.
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, 3'd3, 3'd0);
    idleCycles(2, 3'd3, 3'd0);

    // Dual enqueue to the same register: youngest data must be forwarded.
    applyStimulus(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 3'd2, 3'd2);
    idleCycles(3, 3'd2, 3'd0);

    // Backpressure at count = DEPTH-1.
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202, 3'd1, 3'd2);
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404, 3'd3, 3'd4);
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h0505, 1'b1, 3'd6, 16'h0606, 3'd5, 3'd6);
    idleCycles(4, 3'd5, 3'd6);

    // Zero destination is accepted and discarded.
    applyStimulus(1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    idleCycles(1, 3'd0, 3'd0);

    // Pending mask for registers 5 and 7.
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd7, 16'h7777, 3'd5, 3'd7);
    idleCycles(3, 3'd5, 3'd7);

    // Reset in the middle of a full-ish queue.
    applyStimulus(1'b1, 1'b1, 3'd1, 16'hC001, 1'b1, 3'd2, 16'hC002, 3'd1, 3'd2);
    applyStimulus(1'b1, 1'b1, 3'd3, 16'hC003, 1'b1, 3'd4, 16'hC004, 3'd3, 3'd4);
    applyStimulus(1'b0, 1'b1, 3'd5, 16'hC005, 1'b1, 3'd6, 16'hC006, 3'd3, 3'd4);
    idleCycles(3, 3'd3, 3'd4);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 49) != 0),
                    1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
